// File: rtl/frame_stream_rx_buffer.sv
// Receive end of the frame-processor output stream: strips the 2-byte header, stores frame
// bodies in a circular byte buffer and queues one {portmap,0,len} descriptor per good frame.
module frame_stream_rx_buffer #(
  parameter int DATA_AW   = 11,
  parameter int PTR_AW    = 4,
  parameter int MAX_FRAME = 1536,
  parameter int MIN_BODY  = 14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sof,
  input  logic        dv,
  input  logic [7:0]  data,
  output logic        bp,
  input  logic        sfifo_rd,
  output logic [7:0]  sfifo_dout,
  input  logic        ptr_sfifo_rd,
  output logic [15:0] ptr_sfifo_dout,
  output logic        ptr_sfifo_empty,
  output logic [15:0] drop_cnt,
  output logic [2:0]  dbg_state
);
  // Handshakes: sof/dv is a push stream with no ready; bp only asks the sender not to start a
  // new frame. sfifo_rd/ptr_sfifo_rd are read strobes, data valid the next cycle, ignored when empty.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR1   = 3'd1,
    S_BODY   = 3'd2,
    S_COMMIT = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  localparam int                BUF_DEPTH_I = 1 << DATA_AW;
  localparam int                DESC_DEPTH_I = 1 << PTR_AW;
  localparam logic [DATA_AW:0]  BUF_DEPTH  = (DATA_AW+1)'(BUF_DEPTH_I);
  localparam logic [DATA_AW:0]  MAX_FREE   = (DATA_AW+1)'(MAX_FRAME);
  localparam logic [PTR_AW:0]   DESC_DEPTH = (PTR_AW+1)'(DESC_DEPTH_I);
  localparam logic [PTR_AW:0]   DESC_HIGH  = (PTR_AW+1)'(DESC_DEPTH_I - 1);
  localparam logic [10:0]       MIN_LEN    = 11'(MIN_BODY);
  localparam logic [10:0]       MAX_LEN    = 11'h7FF;

  state_t           r_state, w_next_state;
  logic [DATA_AW:0] r_wr_ptr, r_wr_ptr_tmp, r_rd_ptr;
  logic [PTR_AW:0]  r_desc_wr, r_desc_rd;
  logic [3:0]       r_portmap;
  logic [10:0]      r_body_len;
  logic             r_ovf, r_bp;
  logic [7:0]       r_sfifo_dout;
  logic [15:0]      r_ptr_dout, r_drop_cnt;
  logic [7:0]       r_mem [BUF_DEPTH_I];
  logic [15:0]      r_desc_mem [DESC_DEPTH_I];

  logic [DATA_AW:0] w_used, w_committed, w_free;
  logic [PTR_AW:0]  w_desc_cnt;
  logic w_new_frame, w_body_beat, w_ovf_hit, w_write, w_commit_ok, w_drop;
  logic w_desc_empty, w_desc_full, w_rd_ok, w_ptr_rd_ok;

  // w_used counts the uncommitted frame too, so a frame in flight reserves its space.
  assign w_used       = r_wr_ptr_tmp - r_rd_ptr;
  assign w_committed  = r_wr_ptr - r_rd_ptr;
  assign w_free       = BUF_DEPTH - w_used;
  assign w_desc_cnt   = r_desc_wr - r_desc_rd;
  assign w_desc_empty = (w_desc_cnt == '0);
  assign w_desc_full  = (w_desc_cnt == DESC_DEPTH);

  assign w_new_frame = sof & dv;
  assign w_body_beat = (r_state == S_BODY) & dv & ~sof;
  assign w_ovf_hit   = w_body_beat & ~r_ovf & ((w_used == BUF_DEPTH) | (r_body_len == MAX_LEN));
  assign w_write     = w_body_beat & ~r_ovf & ~w_ovf_hit;
  assign w_commit_ok = (r_state == S_COMMIT) & (r_body_len >= MIN_LEN) & (r_portmap != 4'd0)
                     & ~r_ovf & ~w_desc_full;
  assign w_drop      = ((r_state == S_COMMIT) & ~w_commit_ok) | (r_state == S_ABORT)
                     | (((r_state == S_HDR1) | (r_state == S_BODY)) & w_new_frame);
  assign w_rd_ok     = sfifo_rd & (w_committed != '0);
  assign w_ptr_rd_ok = ptr_sfifo_rd & ~w_desc_empty;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_new_frame) w_next_state = S_HDR1;
      S_HDR1:   if (w_new_frame) w_next_state = S_HDR1;
                else if (dv)     w_next_state = S_BODY;
                else             w_next_state = S_ABORT;
      S_BODY:   if (w_new_frame) w_next_state = S_HDR1;
                else if (!dv)    w_next_state = S_COMMIT;
      S_COMMIT,
      S_ABORT:  w_next_state = w_new_frame ? S_HDR1 : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_wr_ptr_tmp <= '0;
      r_rd_ptr     <= '0;
      r_desc_wr    <= '0;
      r_desc_rd    <= '0;
      r_portmap    <= '0;
      r_body_len   <= '0;
      r_ovf        <= 1'b0;
      r_bp         <= 1'b0;
      r_sfifo_dout <= '0;
      r_ptr_dout   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_bp    <= (w_free < MAX_FREE) | (w_desc_cnt >= DESC_HIGH);
      if (w_new_frame) begin
        r_portmap  <= data[3:0];
        r_body_len <= '0;
        r_ovf      <= 1'b0;
      end
      if (w_write) begin
        r_wr_ptr_tmp <= r_wr_ptr_tmp + 1'b1;
        r_body_len   <= r_body_len + 11'd1;
      end
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_commit_ok) begin
        r_wr_ptr  <= r_wr_ptr_tmp;
        r_desc_wr <= r_desc_wr + 1'b1;
      end
      // Rollback discards the partial body; the new frame (if any) restarts from wr_ptr.
      if (w_drop) begin
        r_wr_ptr_tmp <= r_wr_ptr;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_rd_ok) begin
        r_sfifo_dout <= r_mem[r_rd_ptr[DATA_AW-1:0]];
        r_rd_ptr     <= r_rd_ptr + 1'b1;
      end
      if (w_ptr_rd_ok) begin
        r_ptr_dout <= r_desc_mem[r_desc_rd[PTR_AW-1:0]];
        r_desc_rd  <= r_desc_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr_tmp[DATA_AW-1:0]] <= data;
    if (w_commit_ok) r_desc_mem[r_desc_wr[PTR_AW-1:0]] <= {r_portmap, 1'b0, r_body_len};
  end

  assign bp              = r_bp;
  assign sfifo_dout      = r_sfifo_dout;
  assign ptr_sfifo_dout  = r_ptr_dout;
  assign ptr_sfifo_empty = w_desc_empty;
  assign drop_cnt        = r_drop_cnt;
  assign dbg_state       = r_state;
endmodule

// File: tb/tb_frame_stream_rx_buffer.sv
// Bench for frame_stream_rx_buffer: table-driven frames, hand-written corner sequences and
// randomized frames scored against a frame-level queue model of buffer and descriptor FIFO.
module tb_frame_stream_rx_buffer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sof = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        sfifo_rd = 1'b0;
  logic        ptr_sfifo_rd = 1'b0;
  logic        bp;
  logic [7:0]  sfifo_dout;
  logic [15:0] ptr_sfifo_dout;
  logic        ptr_sfifo_empty;
  logic [15:0] drop_cnt;
  logic [2:0]  dbg_state;

  frame_stream_rx_buffer dut (
    .clk(clk), .rstn(rstn), .sof(sof), .dv(dv), .data(data), .bp(bp),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout),
    .ptr_sfifo_empty(ptr_sfifo_empty), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pm;
    int          len;
    bit          exp_ok;
    logic [15:0] exp_desc;
  } vec_t;

  vec_t        vecs [9];
  logic [7:0]  exp_q [$];
  logic [15:0] desc_q [$];
  logic [7:0]  frame_q [$];
  int          exp_drop = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bp_model();
    return ((2048 - exp_q.size()) < 1536) || (desc_q.size() >= 15);
  endfunction

  // kind 0: complete frame; 1: header byte only then dv low; 2: stop after body with dv still high
  task automatic send_frame(input logic [3:0] pm, input int len, input int kind);
    logic [10:0] l;
    l = 11'(len);
    frame_q.delete();
    @(negedge clk); sof = 1'b1; dv = 1'b1; data = {1'b0, l[10:8], pm};
    @(negedge clk); sof = 1'b0;
    if (kind == 1) begin
      dv = 1'b0; data = 8'h00;
      repeat (3) @(negedge clk);
      return;
    end
    data = l[7:0];
    for (int i = 0; i < len; i++) begin
      @(negedge clk); data = 8'($urandom_range(0, 255));
      frame_q.push_back(data);
    end
    if (kind == 2) return;
    @(negedge clk); dv = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  // Frame-level acceptance rule: enough body, a destination, room for the whole body, a free descriptor.
  task automatic model_frame(input logic [3:0] pm, input int len);
    if (pm != 4'd0 && len >= 14 && exp_q.size() + len <= 2048 && desc_q.size() < 16) begin
      foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
      desc_q.push_back({pm, 1'b0, 11'(len)});
    end else begin
      exp_drop++;
    end
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
    check({tag, "_bp"}, bp, bp_model());
    check({tag, "_empty"}, ptr_sfifo_empty, desc_q.size() == 0);
  endtask

  task automatic check_byte(input logic [7:0] act);
    if (exp_q.size() == 0) begin
      check("byte_unexpected", 1, 0);
    end else begin
      check("byte", act, exp_q.pop_front());
    end
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sfifo_rd = 1'b1;
      if (i > 0) check_byte(sfifo_dout);
    end
    @(negedge clk); sfifo_rd = 1'b0;
    if (n > 0) check_byte(sfifo_dout);
  endtask

  task automatic drain_one();
    logic [15:0] e;
    if (desc_q.size() == 0) return;
    e = desc_q.pop_front();
    check("desc_avail", ptr_sfifo_empty, 0);
    @(negedge clk); ptr_sfifo_rd = 1'b1;
    @(negedge clk); ptr_sfifo_rd = 1'b0;
    check("desc", ptr_sfifo_dout, e);
    read_bytes(int'(e[10:0]));
  endtask

  task automatic drain_all();
    while (desc_q.size() > 0) drain_one();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h5,   64, 1'b1, 16'h5040};
    vecs[1] = '{4'h0,   64, 1'b0, 16'h0000};
    vecs[2] = '{4'h3,   10, 1'b0, 16'h0000};
    vecs[3] = '{4'h3,   13, 1'b0, 16'h0000};
    vecs[4] = '{4'h3,   14, 1'b1, 16'h300E};
    vecs[5] = '{4'hF,  100, 1'b1, 16'hF064};
    vecs[6] = '{4'h1, 1500, 1'b1, 16'h15DC};
    vecs[7] = '{4'h8,   15, 1'b1, 16'h800F};
    vecs[8] = '{4'hA, 1536, 1'b1, 16'hA600};

    // Reset state, then reads on an empty buffer must be ignored
    repeat (3) @(negedge clk);
    check("rst_empty", ptr_sfifo_empty, 1);
    check("rst_bp", bp, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_dout", sfifo_dout, 0);
    check("rst_ptr_dout", ptr_sfifo_dout, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    @(negedge clk); sfifo_rd = 1'b1; ptr_sfifo_rd = 1'b1;
    @(negedge clk); sfifo_rd = 1'b0; ptr_sfifo_rd = 1'b0;
    @(negedge clk);
    check("empty_rd_dout", sfifo_dout, 0);
    check("empty_rd_ptr_dout", ptr_sfifo_dout, 0);
    check("empty_rd_empty", ptr_sfifo_empty, 1);

    // Table of single frames, each drained before the next
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].pm, vecs[v].len, 0);
      if (vecs[v].exp_ok) begin
        foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
        desc_q.push_back(vecs[v].exp_desc);
      end else begin
        exp_drop++;
      end
      post_checks("vec");
      drain_all();
    end

    // Two 1500-byte frames with no reads: the second cannot fit
    send_frame(4'h2, 1500, 0); model_frame(4'h2, 1500);
    post_checks("fill1");
    check("fill1_bp_set", bp, 1);
    send_frame(4'h2, 1500, 0); model_frame(4'h2, 1500);
    post_checks("fill2");
    drain_all();

    // sof reasserted 20 bytes into a body, then a header-only frame
    send_frame(4'h6, 20, 2); exp_drop++;
    send_frame(4'h9, 40, 0); model_frame(4'h9, 40);
    check("restart_desc_front", desc_q.size() == 1 ? 32'(desc_q[0]) : 32'h0, 32'h9028);
    post_checks("restart");
    drain_all();
    send_frame(4'h3, 30, 1); exp_drop++;
    post_checks("hdr_only");

    // Seventeen small frames with no reads: bp at 15 descriptors, 17th dropped
    for (int f = 0; f < 17; f++) begin
      send_frame(4'h1, 20, 0); model_frame(4'h1, 20);
      post_checks("descfull");
    end
    drain_all();

    // Reset in the middle of a body with a committed frame still queued
    send_frame(4'h7, 30, 0); model_frame(4'h7, 30);
    send_frame(4'h7, 30, 2);
    @(negedge clk); rstn = 1'b0; sof = 1'b0; dv = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_empty", ptr_sfifo_empty, 1);
    check("midrst_bp", bp, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    rstn = 1'b1;
    exp_q.delete(); desc_q.delete(); exp_drop = 0;
    @(negedge clk);
    send_frame(4'h4, 50, 0); model_frame(4'h4, 50);
    post_checks("after_rst");
    drain_all();

    // Randomized frames with partial draining, wrapping the byte pointer several times
    for (int f = 0; f < 48; f++) begin
      int kind;
      int len;
      logic [3:0] pm;
      kind = $urandom_range(0, 9);
      pm   = 4'($urandom_range(0, 15));
      len  = $urandom_range(5, 200);
      if (kind == 0) begin
        send_frame(pm, len, 1); exp_drop++;
      end else begin
        if (kind == 1) begin
          send_frame(4'hC, $urandom_range(1, 50), 2); exp_drop++;
        end
        send_frame(pm, len, 0); model_frame(pm, len);
      end
      post_checks("rand");
      for (int d = $urandom_range(0, 2); d > 0; d--) drain_one();
    end
    drain_all();
    post_checks("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
